button_debounce: RTL

- Conditions one raw, bouncy push-button input into a clean, glitch-free level on the sp_clk domain.
- Sits directly upstream of the single-pulse edge detector: btn_clean drives that stage's btn input.
- Structure: 2-FF synchroniser, then a stability counter with a two-state FSM.
- Also keeps a wrap-around count of debounced presses for debug/LED display.

---
 rtl/button_debounce_if.sv | 22 ++
 rtl/button_debounce.sv | 109 ++++++++++
 2 files changed

// File: rtl/button_debounce_if.sv
// Button debounce signal bundle: raw button in, clean level,
// press counter and long-press flag out.
interface button_debounce_if;
    logic       btn_raw;
    logic       btn_clean;
    logic [7:0] press_count;
    logic       long_press;

    modport master (
        output btn_raw,
        input  btn_clean,
        input  press_count,
        input  long_press
    );

    modport slave (
        input  btn_raw,
        output btn_clean,
        output press_count,
        output long_press
    );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-FF synchroniser, stability counter FSM, press count.
// Optional long-press detect under BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
    parameter int unsigned STABLE_CYCLES = 20,
    parameter int unsigned HOLD_CYCLES   = 1000
) (
    input logic             sp_clk,
    input logic             rst,
    button_debounce_if.slave bus
);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

    localparam logic [15:0] LAST = 16'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
        $error("STABLE_CYCLES out of range");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("HOLD_CYCLES out of range");
    end

    logic        s1;
    logic        s2;
    logic [15:0] cnt;
    state_t      state;
    logic        clean_q;
    logic [7:0]  press_q;

    always_ff @(posedge sp_clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            state   <= LOW;
            clean_q <= 1'b0;
            press_q <= '0;
        end else begin
            s1 <= bus.btn_raw;
            s2 <= s1;
            unique case (state)
                LOW: begin
                    // any low sample restarts the stability window
                    if (!s2) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state   <= HIGH;
                        clean_q <= 1'b1;
                        cnt     <= '0;
                        press_q <= press_q + 8'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (s2) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state   <= LOW;
                        clean_q <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign bus.btn_clean   = clean_q;
    assign bus.press_count = press_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [15:0] HOLD   = 16'(HOLD_CYCLES);
    localparam logic [15:0] HOLD_L = 16'(HOLD_CYCLES - 1);

    logic        fall;
    logic [15:0] hcnt;
    logic        lp_q;

    assign fall = (state == HIGH) && !s2 && (cnt == LAST);

    // cleared on the same edge btn_clean drops, so long_press never outlives it
    always_ff @(posedge sp_clk) begin
        if (rst) begin
            hcnt <= '0;
            lp_q <= 1'b0;
        end else if (fall) begin
            hcnt <= '0;
            lp_q <= 1'b0;
        end else if (clean_q) begin
            if (hcnt != HOLD) begin
                hcnt <= hcnt + 16'd1;
            end
            if (hcnt == HOLD_L) begin
                lp_q <= 1'b1;
            end
        end
    end

    assign bus.long_press = lp_q;
`else
    assign bus.long_press = 1'b0;
`endif

endmodule
